reg_strobe_sequencer: RTL and testbench
=======================================

Name: reg_strobe_sequencer

Overview:
- Shares one bank of emulated async-style registers between two bus requesters: CPU (port 0) and DMA/blitter (port 1).
- Converts each accepted write into a clean write-clock pulse on the target register's c input, sized so the register's negedge-clock edge detector sees exactly one rising edge.
- Drives the shared d bus with the write data.
- Sits between the bus decode logic and the register bank, all in the single 'clock' domain.

Parameters:
- NREG, 8, number of register groups, i.e. number of c strobes.
- AW, 3, address width; must satisfy 2**AW >= NREG.
- DW, 16, data width; one bit per register instance within a group.
- HOLD, 1, number of cycles c is held high, minimum 1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  write request, [0]=CPU, [1]=DMA.
- req_addr0  in  AW  CPU target group.
- req_data0  in  DW  CPU write data.
- req_addr1  in  AW  DMA target group.
- req_data1  in  DW  DMA write data.
- req_ready  out  2  one-hot accept strobe; a request transfers when valid & ready.
- reg_c  out  NREG  per-group write clock, wired to each register's c.
- reg_d  out  DW  shared write data, wired to each register's d.
- busy  out  1  high in any state other than IDLE.
- last_grant  out  1  requester of the most recent accepted write.
- addr_err  out  1  one-cycle pulse when an accepted address is >= NREG.

Behaviour:
- Reset values: req_ready=0, reg_c=0, reg_d=0, busy=0, last_grant=1 (so CPU wins the first tie), addr_err=0, state=IDLE. Reset mid-sequence forces reg_c=0 on the next edge and abandons the write.
- FSM states and transitions:
  - IDLE: req_ready is combinational and asserted only in IDLE.
    - Both valid: grant the requester != last_grant (round-robin).
    - One valid: grant that requester.
    - On accept: latch addr/data, update last_grant, go to SETUP.
    - Out-of-range address: accept, pulse addr_err next cycle, stay IDLE, no strobe.
  - SETUP (1 cycle): reg_d=latched data, reg_c=0. Gives half-cycle setup before the register's negedge sample.
  - STROBE (HOLD cycles, counted by a down-counter): reg_c[addr]=1, all other bits 0, reg_d held.
  - RELEASE (1 cycle): reg_c=0, reg_d held. Guarantees c is seen low before any later rising edge, including a back-to-back write to the same group. Then go to IDLE.
- Latency and throughput: the accept cycle is T; reg_c rises at T+2 and falls at T+2+HOLD. A new accept is possible at T+3+HOLD, so throughput is 1 write per HOLD+3 cycles.
- reg_d changes only on the SETUP entry edge and is otherwise held, never glitching while any c is high.
- At most one reg_c bit is high at any time, and only in STROBE.
- Requests arriving while busy are not accepted; requesters hold valid/addr/data until ready.
- A requester deasserting valid before ready simply withdraws its request; this is not an error.
- Round-robin fairness: under continuous contention, grants strictly alternate 0,1,0,1.

Decomposition:
- Shared package reg_seq_pkg: state enum (IDLE, SETUP, STROBE, RELEASE), requester index constants CPU=0 and DMA=1, minimum-HOLD assertion constant.
- One natural sub-module: rr_arb2, the 2-way round-robin arbiter (valid[1:0], last_grant -> grant one-hot). Everything else stays in the top module.

Test Plan:
- Single CPU write, addr=3, data=16'hA5A5, HOLD=1:
  - ready[0] at T;
  - reg_d=A5A5 from T+1;
  - reg_c=8'b0000_1000 only at T+2;
  - busy low at T+4;
  - bank group 3 reads A5A5.
- Simultaneous CPU (addr 1, 16'h1111) and DMA (addr 2, 16'h2222) held continuously after reset:
  - CPU granted first, DMA next at T+4;
  - no reg_c overlap;
  - groups 1 and 2 hold 1111 and 2222.
- Back-to-back CPU writes to addr 5 (16'h0001 then 16'h0002):
  - reg_c[5] low for at least 2 cycles between pulses;
  - the register captures both values in order, final 0002.
- HOLD=3, addr 0: reg_c[0] high for exactly 3 consecutive cycles; a single capture occurs.
- Reset asserted during STROBE:
  - reg_c=0 and busy=0 on the next edge;
  - the pending request is re-accepted after reset deasserts.
- NREG=6, DMA addr 7:
  - req_ready[1] pulses;
  - addr_err pulses once;
  - reg_c stays 0;
  - last_grant becomes 1.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register write-strobe sequencer.
package reg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } seq_state_e;

  localparam logic CPU = 1'b0;
  localparam logic DMA = 1'b1;

  // The strobe must be high for at least one full cycle to be seen as an edge.
  localparam int MIN_HOLD = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arb2
  import reg_seq_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid[CPU] && valid[DMA]) begin
      if (last_grant == CPU) grant[DMA] = 1'b1;
      else                   grant[CPU] = 1'b1;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/reg_strobe_sequencer.sv
// Turns accepted CPU/DMA register writes into a single clean write-clock pulse per write.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | ready offered to the arbitration winner; accept latches
//   ST_SETUP   | reg_d driven, all c low (setup before register sample)
//   ST_STROBE  | one c bit high for HOLD cycles (down-counter)
//   ST_RELEASE | all c low, reg_d held, so the next pulse is a new edge
module reg_strobe_sequencer
  import reg_seq_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16,
  parameter int HOLD = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  input  logic [AW-1:0]   req_addr0,
  input  logic [DW-1:0]   req_data0,
  input  logic [AW-1:0]   req_addr1,
  input  logic [DW-1:0]   req_data1,
  output logic [1:0]      req_ready,
  output logic [NREG-1:0] reg_c,
  output logic [DW-1:0]   reg_d,
  output logic            busy,
  output logic            last_grant,
  output logic            addr_err
);

  localparam int HOLD_EFF = (HOLD < MIN_HOLD) ? MIN_HOLD : HOLD;
  localparam int CW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_EFF - 1);

  seq_state_e      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   reg_d_q, reg_d_d;
  logic [NREG-1:0] reg_c_q, reg_c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            addr_err_q, addr_err_d;

  logic [1:0]      grant;
  logic            accept;
  logic            sel_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            addr_ok;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    sel_idx  = req_ready[DMA];
    sel_addr = sel_idx ? req_addr1 : req_addr0;
    sel_data = sel_idx ? req_data1 : req_data0;
    addr_ok  = int'(sel_addr) < NREG;
    accept   = |req_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      reg_d_q      <= '0;
      reg_c_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= DMA;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      reg_d_q      <= reg_d_d;
      reg_c_q      <= reg_c_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    reg_d_d      = reg_d_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_grant_d = sel_idx;
          // Out-of-range writes are consumed so the requester is not stuck.
          if (addr_ok) begin
            addr_d  = sel_addr;
            reg_d_d = sel_data;
            state_d = ST_SETUP;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        cnt_d   = HOLD_LOAD;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == '0) state_d = ST_RELEASE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // reg_c is registered from the next state so the strobe never glitches.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    req_ready = (state_q == ST_IDLE && !reset) ? grant : 2'b00;
    reg_c_d   = '0;
    if (state_d == ST_STROBE) begin
      for (int i = 0; i < NREG; i++) reg_c_d[i] = (addr_q == AW'(i));
    end
  end

  assign reg_c      = reg_c_q;
  assign reg_d      = reg_d_q;
  assign last_grant = last_grant_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_reg_strobe_sequencer.sv
// Directed bench: two sequencer instances (8 groups/HOLD=1 and 6 groups/HOLD=3) with a negedge register-bank model.
module tb_reg_strobe_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Instance A: NREG=8, HOLD=1
  logic        rst_a;
  logic [1:0]  valid_a;
  logic [2:0]  addr0_a, addr1_a;
  logic [15:0] data0_a, data1_a;
  logic [1:0]  ready_a;
  logic [7:0]  c_a;
  logic [15:0] d_a;
  logic        busy_a, lg_a, err_a;

  // Instance B: NREG=6, HOLD=3
  logic        rst_b;
  logic [1:0]  valid_b;
  logic [2:0]  addr0_b, addr1_b;
  logic [15:0] data0_b, data1_b;
  logic [1:0]  ready_b;
  logic [5:0]  c_b;
  logic [15:0] d_b;
  logic        busy_b, lg_b, err_b;

  reg_strobe_sequencer #(.NREG(8), .AW(3), .DW(16), .HOLD(1)) dut_a (
    .clock(clock), .reset(rst_a), .req_valid(valid_a),
    .req_addr0(addr0_a), .req_data0(data0_a), .req_addr1(addr1_a), .req_data1(data1_a),
    .req_ready(ready_a), .reg_c(c_a), .reg_d(d_a), .busy(busy_a),
    .last_grant(lg_a), .addr_err(err_a)
  );

  reg_strobe_sequencer #(.NREG(6), .AW(3), .DW(16), .HOLD(3)) dut_b (
    .clock(clock), .reset(rst_b), .req_valid(valid_b),
    .req_addr0(addr0_b), .req_data0(data0_b), .req_addr1(addr1_b), .req_data1(data1_b),
    .req_ready(ready_b), .reg_c(c_b), .reg_d(d_b), .busy(busy_b),
    .last_grant(lg_b), .addr_err(err_b)
  );

  // Register bank: each register captures d when its c is seen rising at a negedge sample.
  logic [15:0] bank_a [8] = '{default: '0};
  int          cnt_a  [8] = '{default: 0};
  logic [7:0]  prev_a = '0;
  logic [15:0] bank_b [6] = '{default: '0};
  int          cnt_b  [6] = '{default: 0};
  logic [5:0]  prev_b = '0;

  always @(negedge clock) begin
    for (int g = 0; g < 8; g++) begin
      if (c_a[g] && !prev_a[g]) begin
        bank_a[g] <= d_a;
        cnt_a[g]  <= cnt_a[g] + 1;
      end
    end
    prev_a <= c_a;
  end

  always @(negedge clock) begin
    for (int g = 0; g < 6; g++) begin
      if (c_b[g] && !prev_b[g]) begin
        bank_b[g] <= d_b;
        cnt_b[g]  <= cnt_b[g] + 1;
      end
    end
    prev_b <= c_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1; valid_a = 2'b00; addr0_a = '0; data0_a = '0; addr1_a = '0; data1_a = '0;
    rst_b = 1'b1; valid_b = 2'b00; addr0_b = '0; data0_b = '0; addr1_b = '0; data1_b = '0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_ready_a", ready_a, 2'b00);
    check("rst_c_a",     c_a,     8'h00);
    check("rst_d_a",     d_a,     16'h0000);
    check("rst_busy_a",  busy_a,  1'b0);
    check("rst_lg_a",    lg_a,    1'b1);
    check("rst_err_a",   err_a,   1'b0);
    check("rst_lg_b",    lg_b,    1'b1);
    check("rst_busy_b",  busy_b,  1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clock);

    // Single CPU write, addr 3
    valid_a = 2'b01; addr0_a = 3'd3; data0_a = 16'hA5A5;
    #1 check("t1_ready_T", ready_a, 2'b01);
    @(negedge clock);
    check("t1_d_T1",     d_a,     16'hA5A5);
    check("t1_c_T1",     c_a,     8'h00);
    check("t1_busy_T1",  busy_a,  1'b1);
    check("t1_ready_T1", ready_a, 2'b00);
    check("t1_lg",       lg_a,    1'b0);
    valid_a = 2'b00;
    @(negedge clock);
    check("t1_c_T2",     c_a,     8'b0000_1000);
    check("t1_d_T2",     d_a,     16'hA5A5);
    @(negedge clock);
    check("t1_c_T3",     c_a,     8'h00);
    check("t1_busy_T3",  busy_a,  1'b1);
    @(negedge clock);
    check("t1_busy_T4",  busy_a,  1'b0);
    check("t1_bank3",    bank_a[3], 16'hA5A5);
    check("t1_cnt3",     cnt_a[3],  1);

    // Continuous contention right after reset: CPU, DMA, CPU
    rst_a = 1'b1; valid_a = 2'b11;
    addr0_a = 3'd1; data0_a = 16'h1111; addr1_a = 3'd2; data1_a = 16'h2222;
    @(negedge clock);
    rst_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("t2_ready_k%0d", k), ready_a,
            (k == 0 || k == 8) ? 2'b01 : (k == 4) ? 2'b10 : 2'b00);
      check($sformatf("t2_c_k%0d", k), c_a,
            (k == 2 || k == 10) ? 8'h02 : (k == 6) ? 8'h04 : 8'h00);
      @(negedge clock);
    end
    valid_a = 2'b00;
    repeat (2) @(negedge clock);
    check("t2_bank1", bank_a[1], 16'h1111);
    check("t2_bank2", bank_a[2], 16'h2222);
    check("t2_cnt1",  cnt_a[1],  2);
    check("t2_cnt2",  cnt_a[2],  1);

    // Back-to-back CPU writes to group 5
    valid_a = 2'b01; addr0_a = 3'd5; data0_a = 16'h0001;
    for (int k = 0; k < 9; k++) begin
      if (k == 1) data0_a = 16'h0002;
      if (k == 5) valid_a = 2'b00;
      #1;
      check($sformatf("t3_c_k%0d", k), c_a, (k == 2 || k == 6) ? 8'h20 : 8'h00);
      if (k == 0 || k == 4) check($sformatf("t3_ready_k%0d", k), ready_a, 2'b01);
      if (k == 4) begin
        check("t3_bank5_first", bank_a[5], 16'h0001);
        check("t3_cnt5_first",  cnt_a[5],  1);
      end
      @(negedge clock);
    end
    check("t3_bank5_final", bank_a[5], 16'h0002);
    check("t3_cnt5_final",  cnt_a[5],  2);

    // HOLD=3 on instance B, group 0
    valid_b = 2'b01; addr0_b = 3'd0; data0_b = 16'h5A5A;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) valid_b = 2'b00;
      #1;
      check($sformatf("t4_c_k%0d", k), c_b, (k >= 2 && k <= 4) ? 6'h01 : 6'h00);
      check($sformatf("t4_busy_k%0d", k), busy_b, (k >= 1 && k <= 5) ? 1'b1 : 1'b0);
      @(negedge clock);
    end
    check("t4_cnt0",  cnt_b[0],  1);
    check("t4_bank0", bank_b[0], 16'h5A5A);

    // Reset during STROBE, request held and re-accepted
    valid_b = 2'b01; addr0_b = 3'd4; data0_b = 16'h0F0F;
    #1 check("t5_ready_T", ready_b, 2'b01);
    repeat (2) @(negedge clock);
    #1 check("t5_c_strobe", c_b, 6'h10);
    rst_b = 1'b1;
    @(negedge clock);
    #1;
    check("t5_c_after_rst",     c_b,     6'h00);
    check("t5_busy_after_rst",  busy_b,  1'b0);
    check("t5_ready_in_rst",    ready_b, 2'b00);
    rst_b = 1'b0;
    #1 check("t5_ready_reaccept", ready_b, 2'b01);
    @(negedge clock);
    valid_b = 2'b00;
    #1 check("t5_busy_setup", busy_b, 1'b1);
    @(negedge clock);
    #1 check("t5_c_restrobe", c_b, 6'h10);
    repeat (4) @(negedge clock);
    #1;
    check("t5_busy_done", busy_b, 1'b0);
    check("t5_cnt4",      cnt_b[4], 2);
    check("t5_bank4",     bank_b[4], 16'h0F0F);

    // Out-of-range DMA write on the 6-group instance
    check("t6_lg_before", lg_b, 1'b0);
    valid_b = 2'b10; addr1_b = 3'd7; data1_b = 16'hBEEF;
    #1 check("t6_ready", ready_b, 2'b10);
    @(negedge clock);
    valid_b = 2'b00;
    #1;
    check("t6_err_pulse", err_b,  1'b1);
    check("t6_lg",        lg_b,   1'b1);
    check("t6_c_0",       c_b,    6'h00);
    check("t6_busy",      busy_b, 1'b0);
    check("t6_d_kept",    d_b,    16'h0F0F);
    @(negedge clock);
    #1;
    check("t6_err_once",  err_b,  1'b0);
    check("t6_c_1",       c_b,    6'h00);
    check("t6_busy_1",    busy_b, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
